// File: rtl/snake_pkg.sv
// Shared geometry for the snake game: grid cell size, grid and screen dimensions,
// and the pixel coordinate type used on every position port.
package snake_pkg;

  localparam int CELL     = 20;
  localparam int GRID_W   = 32;
  localparam int GRID_H   = 24;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/apple_logic_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left one bit per enabled tick.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  logic fb;

  // Feedback from taps 16, 14, 13 and 11 (bit indices 15, 13, 12, 10).
  always_comb begin
    fb = q[15] ^ q[13] ^ q[12] ^ q[10];
  end

  // Synchronous reset to the seed; shift left with feedback into bit 0.
  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[14:0], fb};
    end
  end

endmodule

// File: rtl/apple_logic.sv
// Snake-game apple/score unit. Every game tick the snake head is compared with the
// displayed apple; a hit bumps the score, pulses eaten and publishes a new apple cell
// drawn from the LFSR. The renderer picks up the new apple when score[0] toggles.
module apple_logic
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter coord_t      INIT_X = 10'd320,
  parameter coord_t      INIT_Y = 10'd240
) (
  input  logic       clk4,
  input  logic       rst,
  input  coord_t     newposx,
  input  coord_t     newposy,
  input  coord_t     applex,
  input  coord_t     appley,
  output logic [7:0] score,
  output coord_t     newapplex,
  output coord_t     newappley,
  output logic       eaten
);

  logic [15:0] lfsr;
  logic        match;
  logic [4:0]  cx;
  logic [4:0]  cy_raw;
  logic [4:0]  cy;
  coord_t      cx_w;
  coord_t      cy_w;
  coord_t      px_raw;
  coord_t      px_bump;
  coord_t      px;
  coord_t      py;

  // Free-running random source; advances on every non-reset tick.
  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk4),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr)
  );

  // Hit detection and mapping of the current LFSR value to an on-grid apple cell.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latches are inferred.
    match   = (newposx == applex) && (newposy == appley);
    cx      = lfsr[4:0];
    cy_raw  = lfsr[9:5];
    cy      = (cy_raw >= 5'(GRID_H)) ? (cy_raw - 5'(GRID_H)) : cy_raw;
    cx_w    = {5'd0, cx};
    cy_w    = {5'd0, cy};
    // Cell-to-pixel scaling by 20 as x*16 + x*4.
    px_raw  = (cx_w << 4) + (cx_w << 2);
    py      = (cy_w << 4) + (cy_w << 2);
    px_bump = px_raw + coord_t'(CELL);
    if (px_bump == coord_t'(SCREEN_W)) begin
      px_bump = '0;
    end
    // Never drop the new apple directly under the head; slide it one cell right.
    px = ((px_raw == newposx) && (py == newposy)) ? px_bump : px_raw;
  end

  // Score, apple position and eaten pulse; reset overrides a simultaneous hit.
  always_ff @(posedge clk4) begin
    if (rst) begin
      score     <= '0;
      newapplex <= INIT_X;
      newappley <= INIT_Y;
      eaten     <= 1'b0;
    end else if (match) begin
      score     <= score + 8'd1;
      newapplex <= px;
      newappley <= py;
      eaten     <= 1'b1;
    end else begin
      eaten     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apple_logic.sv
// Directed bench for apple_logic: reset, idle hold, single eat, LFSR-driven apple
// placement (row folding, head-collision shift, 620->0 wrap), score wrap and reset priority.
module tb_apple_logic;

  logic       clk4 = 1'b0;
  logic       rst;
  logic [9:0] newposx, newposy, applex, appley;
  logic [7:0] score;
  logic [9:0] newapplex, newappley;
  logic       eaten;

  int n_total = 0;
  int n_pass  = 0;

  // Reference state maintained by the bench.
  logic [15:0] m_lfsr;
  logic [7:0]  m_score;
  int          m_x, m_y;
  logic        m_eaten;

  apple_logic dut (
    .clk4      (clk4),
    .rst       (rst),
    .newposx   (newposx),
    .newposy   (newposy),
    .applex    (applex),
    .appley    (appley),
    .score     (score),
    .newapplex (newapplex),
    .newappley (newappley),
    .eaten     (eaten)
  );

  always #5 clk4 = ~clk4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Apple cell predicted from an LFSR value, before head-collision handling.
  function automatic int pred_x(input logic [15:0] s);
    return int'(s[4:0]) * 20;
  endfunction

  function automatic int pred_y(input logic [15:0] s);
    int cy;
    cy = int'(s[9:5]);
    if (cy >= 24) cy = cy - 24;
    return cy * 20;
  endfunction

  // One game tick: model computed from pre-edge inputs, outputs sampled 1 ns after the edge.
  task automatic step();
    int px, py;
    if (rst) begin
      m_lfsr = 16'hACE1; m_score = 8'd0; m_x = 320; m_y = 240; m_eaten = 1'b0;
    end else begin
      if (newposx == applex && newposy == appley) begin
        px = pred_x(m_lfsr);
        py = pred_y(m_lfsr);
        if (px == int'(newposx) && py == int'(newposy)) px = (px + 20) % 640;
        m_x = px; m_y = py; m_score = m_score + 8'd1; m_eaten = 1'b1;
      end else begin
        m_eaten = 1'b0;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
    @(posedge clk4);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".score"}, 32'(score), 32'(m_score));
    check({tag, ".x"}, 32'(newapplex), 32'(m_x));
    check({tag, ".y"}, 32'(newappley), 32'(m_y));
    check({tag, ".eaten"}, 32'(eaten), 32'(m_eaten));
  endtask

  task automatic set_pos(input int hx, input int hy, input int ax, input int ay);
    newposx = 10'(hx); newposy = 10'(hy); applex = 10'(ax); appley = 10'(ay);
  endtask

  initial begin
    int k;
    int py;
    m_lfsr = 16'hACE1; m_score = 8'd0; m_x = 320; m_y = 240; m_eaten = 1'b0;
    rst = 1'b1;
    set_pos(0, 0, 320, 240);
    @(negedge clk4);

    // 1. Reset for two ticks.
    step(); step();
    check("reset.score", 32'(score), 32'd0);
    check("reset.x", 32'(newapplex), 32'd320);
    check("reset.y", 32'(newappley), 32'd240);
    check("reset.eaten", 32'(eaten), 32'd0);

    // Hand-computed first eat: seed ACE1 -> cx=1, cy=7 -> (20,140).
    rst = 1'b0;
    set_pos(320, 240, 320, 240);
    step();
    check("first_eat.x", 32'(newapplex), 32'd20);
    check("first_eat.y", 32'(newappley), 32'd140);
    check("first_eat.score", 32'(score), 32'd1);
    check("first_eat.eaten", 32'(eaten), 32'd1);
    rst = 1'b1;
    step();
    check_all("rereset");
    rst = 1'b0;

    // 2. No match for 10 ticks: everything holds.
    set_pos(0, 0, 320, 240);
    for (int i = 0; i < 10; i++) begin
      step();
      check_all("idle");
    end

    // 3. Single eat, pulse lasts exactly one tick, result on grid.
    set_pos(320, 240, 320, 240);
    step();
    check_all("eat");
    check("eat.x_grid", 32'(newapplex % 20 == 0 && newapplex <= 620), 32'd1);
    check("eat.y_grid", 32'(newappley % 20 == 0 && newappley <= 460), 32'd1);
    set_pos(0, 0, 320, 240);
    step();
    check("eat.pulse_off", 32'(eaten), 32'd0);
    check_all("eat_after");

    // 4a. Row folding: idle until lfsr[9:5] >= 24, then eat away from the predicted cell.
    set_pos(0, 0, 320, 240);
    k = 0;
    while (m_lfsr[9:5] < 5'd24 && k < 300) begin step(); k++; end
    set_pos(0, 0, 0, 0);
    if (pred_x(m_lfsr) == 0 && pred_y(m_lfsr) == 0) set_pos(20, 20, 20, 20);
    step();
    check_all("fold");
    check("fold.y_range", 32'(newappley <= 460), 32'd1);

    // 4b. Head collision: head sits on the predicted cell, apple slides right.
    set_pos(0, 0, 320, 240);
    k = 0;
    while ((m_lfsr[4:0] == 5'd31 || m_lfsr[4:0] == 5'd0) && k < 300) begin step(); k++; end
    set_pos(pred_x(m_lfsr), pred_y(m_lfsr), pred_x(m_lfsr), pred_y(m_lfsr));
    step();
    check_all("collide");

    // 4c. Collision in the last column wraps 620+20 to 0.
    set_pos(0, 0, 320, 240);
    k = 0;
    while (m_lfsr[4:0] != 5'd31 && k < 300) begin step(); k++; end
    py = pred_y(m_lfsr);
    set_pos(620, py, 620, py);
    step();
    check("wrap.x", 32'(newapplex), 32'd0);
    check_all("wrap");

    // 5. 256 consecutive eats: score wraps and bit 0 toggles every eat.
    set_pos(0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      step();
      check("score_run.score", 32'(score), 32'(m_score));
      check("score_run.bit0", 32'(score[0]), 32'(m_score[0]));
      if (m_score == 8'd0) check("score_run.wrap", 32'(score), 32'd0);
    end
    check_all("score_run_end");

    // 6. Reset coincident with a match: reset wins.
    set_pos(0, 0, 0, 0);
    rst = 1'b1;
    step();
    check("rst_prio.score", 32'(score), 32'd0);
    check("rst_prio.eaten", 32'(eaten), 32'd0);
    check("rst_prio.x", 32'(newapplex), 32'd320);
    check("rst_prio.y", 32'(newappley), 32'd240);
    rst = 1'b0;
    set_pos(320, 240, 320, 240);
    step();
    check("rst_prio.reseed_x", 32'(newapplex), 32'd20);
    check("rst_prio.reseed_y", 32'(newappley), 32'd140);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
